// File: rtl/kamacore_mem_responder_if.sv
// Request/response channel between the memory-stage initiator and the memory responder.
// Two independent valid/ready channels; one transaction in flight at a time.
interface kamacore_mem_responder_if #(
    parameter int unsigned CPU_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [CPU_WIDTH-1:0] req_addr;
    logic [CPU_WIDTH-1:0] req_wdata;
    logic [3:0]           req_be;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CPU_WIDTH-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/kamacore_mem_responder.sv
// Word-organised synchronous RAM responder with a fixed, programmable access latency
// and address/alignment error reporting. One outstanding transaction.
module kamacore_mem_responder #(
    parameter int unsigned CPU_WIDTH   = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    kamacore_mem_responder_if.slave   bus
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned BE_W  = CPU_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [CPU_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 req_ready;
    logic                 req_ready_nxt;
    logic                 rsp_valid;
    logic                 rsp_valid_nxt;
    logic [CPU_WIDTH-1:0] rsp_rdata;
    logic [CPU_WIDTH-1:0] rsp_rdata_nxt;
    logic                 rsp_err;
    logic                 rsp_err_nxt;

    logic                 accept_c;
    logic                 addr_err_c;
    logic                 mem_we_c;
    logic [AW-1:0]        word_idx_c;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;

    // Address decode: misaligned or any bit above the RAM window is an error.
    assign word_idx_c = bus.req_addr[AW+1:2];
    assign addr_err_c = (|bus.req_addr[1:0]) | (|bus.req_addr[CPU_WIDTH-1:AW+2]);
    assign accept_c   = (state == ST_IDLE) & req_ready & bus.req_valid;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        req_ready_nxt = 1'b0;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        mem_we_c      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                req_ready_nxt = 1'b1;
                if (accept_c) begin
                    req_ready_nxt = 1'b0;
                    mem_we_c      = bus.req_we & ~addr_err_c;
                    rsp_err_nxt   = addr_err_c;
                    rsp_rdata_nxt = (!bus.req_we && !addr_err_c) ? mem[word_idx_c] : '0;
                    if (LATENCY == 1) begin
                        state_nxt     = ST_RESP;
                        rsp_valid_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt     = ST_RESP;
                    cnt_nxt       = '0;
                    rsp_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt     = ST_IDLE;
                    rsp_valid_nxt = 1'b0;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                rsp_valid_nxt = 1'b0;
                rsp_rdata_nxt = '0;
                rsp_err_nxt   = 1'b0;
            end
        endcase
    end

    // RAM contents survive reset; stores commit at the accept edge under byte enables.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.req_be[b]) begin
                    mem[word_idx_c][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response payload must hold under backpressure; channels never overlap.
    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst)
        (rsp_valid && !bus.rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)));
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst)
        !(req_ready && rsp_valid));
endmodule

// File: tb/tb_kamacore_mem_responder.sv
// Directed scoreboard bench for kamacore_mem_responder: driver queues expected
// responses, an independent monitor checks data, error, latency and handshake timing.
module tb_kamacore_mem_responder;
    localparam int unsigned CPU_WIDTH   = 32;
    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int unsigned LATENCY     = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];

    kamacore_mem_responder_if #(.CPU_WIDTH(CPU_WIDTH)) bus ();

    kamacore_mem_responder #(
        .CPU_WIDTH  (CPU_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard when a new response appears, checks hold and handshake.
    logic        prev_valid;
    logic        pend_hs;
    logic [31:0] held_rdata;
    logic        held_err;
    initial begin
        prev_valid = 1'b0;
        pend_hs    = 1'b0;
        held_rdata = '0;
        held_err   = 1'b0;
    end

    always @(negedge clk) begin
        exp_t cur;
        if (!rst) begin
            prev_valid = 1'b0;
            pend_hs    = 1'b0;
        end else begin
            if (pend_hs) begin
                chk("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
                chk("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
                pend_hs = 1'b0;
            end
            if (bus.rsp_valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, cur.rdata);
                        chk("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
                        chk("latency", 32'(cyc - cur.acc_cyc), 32'(LATENCY));
                    end
                end else begin
                    chk("hold_rdata", bus.rsp_rdata, held_rdata);
                    chk("hold_err", 32'(bus.rsp_err), 32'(held_err));
                end
                chk("req_ready_during_rsp", 32'(bus.req_ready), 32'd0);
                held_rdata = bus.rsp_rdata;
                held_err   = bus.rsp_err;
                if (bus.rsp_ready) pend_hs = 1'b1;
            end
            prev_valid = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    // Issue one request once the responder is ready; queue its expected response.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = 32'h0000_0044;
        bus.req_wdata = 32'h5A5A_5A5A;
        bus.req_be    = 4'hF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic mid_reset(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        issue(we, addr, wdata, 4'hF, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    initial begin
        int n;
        n_chk  = 0;
        n_fail = 0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        end
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("release_req_ready", 32'(bus.req_ready), 32'd1);
        chk("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        issue(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        issue(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h0, 32'h01234567, 4'hF, 32'h0, 1'b0);
        issue(1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0, 1'b1);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h01234567, 1'b0);
        issue(1'b1, 32'h22, 32'h77777777, 4'hF, 32'h0, 1'b1);
        issue(1'b1, 32'h8000_0010, 32'h66666666, 4'hF, 32'h0, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        issue(1'b1, 32'hFFC, 32'hC0FFEE01, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 32'hFFC, 32'h0, 4'h0, 32'hC0FFEE01, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        drain();

        // Backpressure: hold rsp_ready low for five sampled cycles of a valid response.
        @(negedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        drain();

        mid_reset(1'b1, 32'h40, 32'hCAFEF00D);
        issue(1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        drain();
        mid_reset(1'b0, 32'h10, 32'h0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/kamacore_mem_responder.md
Name: kamacore_mem_responder

Overview:
- Memory-side responder for the core's load/store and fetch request interface; the target end of the initiator protocol driven by the memory stage.
- Word-organised synchronous RAM behind a valid/ready request channel and a valid/ready response channel.
- Programmable fixed access latency; address and alignment error reporting.
- One outstanding transaction at a time.

Parameters:
CPU_WIDTH, 32, data and address width in bits; must be 32.
DEPTH_WORDS, 1024, number of CPU_WIDTH words; power of two.
LATENCY, 2, cycles from request accept to rsp_valid; must be 1..15.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = in reset).
req_valid  input  1  initiator presents a request.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  CPU_WIDTH  byte address.
req_wdata  input  CPU_WIDTH  store data.
req_be  input  4  byte enables for a store; bit i covers wdata[8i+7:8i].
rsp_valid  output  1  response available.
rsp_ready  input  1  initiator accepts the response.
rsp_rdata  output  CPU_WIDTH  load data; 0 for stores and errors.
rsp_err  output  1  1 = misaligned or out-of-range access.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE, latency counter 0; req_ready=0 while rst=0, then 1 from the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not reset.
- Reset asserted mid-transaction drops the transaction. A store already committed stays committed. No response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept edge T occurs when req_valid & req_ready.
  - LATENCY=1 goes to RESP; otherwise goes to WAIT with counter = LATENCY-1.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When the counter reaches 1, next state is RESP.
  - rsp_valid rises exactly LATENCY cycles after edge T.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready.
  - On the handshake edge go to IDLE and drop rsp_valid.
  - req_ready rises on the following cycle. No same-cycle response/request overlap.
  - Best-case throughput is one transaction per LATENCY+1 cycles.
- Address decode:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Error if req_addr[1:0] != 0, or if any address bit above log2(DEPTH_WORDS)+1 is set.
- Store (req_we=1, no error): RAM written at edge T under req_be. Bytes with be=0 are unchanged; be=0000 writes nothing and still gives rsp_err=0. rsp_rdata=0.
- Load (req_we=0, no error): word read at edge T and held in a response register. rsp_rdata is that word.
- Error: no RAM write; rsp_err=1, rsp_rdata=0.
- req_* inputs are sampled only at edge T. Changes while req_ready=0 are ignored.
- rsp_ready while rsp_valid=0 is ignored.
- A load to the address just stored returns the new data, because the store commits at its own edge T.
- Counter width is 4 bits. No wrap is possible under the LATENCY range.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> rsp_valid=0, rsp_rdata=0, rsp_err=0 throughout; req_ready=1 from the first cycle after release.
- Store/load, LATENCY=2, rsp_ready=1: store addr 0x10, data 0xDEADBEEF, be=1111, then load 0x10 -> each rsp_valid exactly 2 cycles after accept; store rsp_err=0, rsp_rdata=0; load rsp_rdata=0xDEADBEEF; next req_ready 1 cycle after each handshake.
- Byte enables: word 0x20 holds 0x11223344; store 0xAABBCCDD with be=0101 -> subsequent load returns 0x11BB33DD. Store be=0000 -> word unchanged, rsp_err=0.
- Errors: load 0x13 -> rsp_err=1, rdata=0. Store to 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1, and a later load of 0x0 shows word 0 unchanged.
- Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 all 5 cycles; handshake on rsp_ready=1, then req_ready=1 the next cycle.
- Mid-operation reset: accept a load, assert rst=0 during WAIT -> rsp_valid=0 immediately and no response after release. Store accepted before the reset remains readable.
